// File: rtl/vend_if.sv
// Vending controller bus: groups the customer/dispenser inputs and the status
// outputs of vend_ctrl.
//   master : drives coin, sel_valid, sel_item, cancel, disp_ack;
//            observes credit, disp_req, disp_item, chg_pulse, coin_reject,
//            sel_err, disp_fault, busy
//   slave  : the controller side (directions reversed)
interface vend_if #(
    parameter int CREDIT_W = 6
);
    logic [1:0]          coin;
    logic                sel_valid;
    logic [1:0]          sel_item;
    logic                cancel;
    logic                disp_ack;
    logic [CREDIT_W-1:0] credit;
    logic                disp_req;
    logic [1:0]          disp_item;
    logic                chg_pulse;
    logic                coin_reject;
    logic                sel_err;
    logic                disp_fault;
    logic                busy;

    modport master (
        output coin, sel_valid, sel_item, cancel, disp_ack,
        input  credit, disp_req, disp_item, chg_pulse, coin_reject,
               sel_err, disp_fault, busy
    );

    modport slave (
        input  coin, sel_valid, sel_item, cancel, disp_ack,
        output credit, disp_req, disp_item, chg_pulse, coin_reject,
               sel_err, disp_fault, busy
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending machine controller: accumulates coin credit, dispenses a selected
// item when credit covers its price, and pays change back one unit per pulse.
//   clk  : system clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : vend_if slave (coin/selection/cancel/ack in; credit, dispense
//          request and event pulses out, all registered)
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_IDLE     | no credit, waiting for the first coin
//   S_CREDIT   | credit held, accepting coins / selection / cancel
//   S_DISPENSE | disp_req high, waiting for disp_ack or watchdog expiry
//   S_CHANGE   | returning remaining credit, one chg_pulse per unit
module vend_ctrl #(
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 40,
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 5,
    parameter int PRICE3     = 6,
    parameter int TIMEOUT    = 1023
) (
    input  logic   clk,
    input  logic   rst,
    vend_if.slave  bus
);

    // The timer is loaded with TIMEOUT-1 and fires when it sits at zero on a
    // quiet cycle, i.e. on the TIMEOUT-th consecutive cycle without activity.
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W + 1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                disp_req_q, disp_req_d;
    logic [1:0]          disp_item_q, disp_item_d;
    logic                chg_q, chg_d;
    logic                rej_q, rej_d;
    logic                sel_err_q, sel_err_d;
    logic                fault_q, fault_d;
    logic                busy_q;
    logic                activity;

    logic [1:0]          coin_val;
    logic                coin_present;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] item_price;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] item);
        case (item)
            2'd0:    return CREDIT_W'(PRICE0);
            2'd1:    return CREDIT_W'(PRICE1);
            2'd2:    return CREDIT_W'(PRICE2);
            default: return CREDIT_W'(PRICE3);
        endcase
    endfunction

    // Code 01 carries no value and is neither accepted nor rejected.
    always_comb begin
        case (bus.coin)
            2'b10:   coin_val = 2'd1;
            2'b11:   coin_val = 2'd2;
            default: coin_val = 2'd0;
        endcase
    end

    assign coin_present = (coin_val != 2'd0);
    // One extra bit so the over-limit test itself can never wrap.
    assign credit_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);
    assign coin_fits    = (credit_sum <= MAX_SUM);
    assign sel_price    = price_of(bus.sel_item);
    assign item_price   = price_of(disp_item_q);

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        timer_d     = timer_q;
        disp_req_d  = disp_req_q;
        disp_item_d = disp_item_q;
        chg_d       = 1'b0;
        rej_d       = 1'b0;
        sel_err_d   = 1'b0;
        fault_d     = 1'b0;
        activity    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.sel_valid) begin
                    sel_err_d = 1'b1;
                end
                if (coin_present) begin
                    if (!bus.sel_valid && !bus.cancel && coin_fits) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end

            S_CREDIT: begin
                if (bus.cancel) begin
                    rej_d   = coin_present;
                    state_d = S_CHANGE;
                end else if (bus.sel_valid) begin
                    rej_d    = coin_present;
                    activity = 1'b1;
                    if (credit_q >= sel_price) begin
                        credit_d    = credit_q - sel_price;
                        disp_item_d = bus.sel_item;
                        disp_req_d  = 1'b1;
                        state_d     = S_DISPENSE;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else if (coin_present && coin_fits) begin
                    credit_d = credit_sum[CREDIT_W-1:0];
                    activity = 1'b1;
                end else begin
                    // A rejected coin does not count as activity.
                    rej_d = coin_present;
                    if (timer_q == '0) begin
                        state_d = S_CHANGE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            S_DISPENSE: begin
                rej_d = coin_present;
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    state_d    = (credit_q != '0) ? S_CHANGE : S_IDLE;
                end else if (timer_q == '0) begin
                    // Dispenser never answered: refund the item price.
                    fault_d    = 1'b1;
                    credit_d   = credit_q + item_price;
                    disp_req_d = 1'b0;
                    state_d    = S_CHANGE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            S_CHANGE: begin
                rej_d = coin_present;
                // Pulse high then low per unit; leave once credit is gone.
                if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else if (!chg_q) begin
                    chg_d    = 1'b1;
                    credit_d = credit_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (activity || (state_d != state_q)) begin
            timer_d = TMR_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            timer_q     <= '0;
            disp_req_q  <= 1'b0;
            disp_item_q <= 2'd0;
            chg_q       <= 1'b0;
            rej_q       <= 1'b0;
            sel_err_q   <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            timer_q     <= timer_d;
            disp_req_q  <= disp_req_d;
            disp_item_q <= disp_item_d;
            chg_q       <= chg_d;
            rej_q       <= rej_d;
            sel_err_q   <= sel_err_d;
            fault_q     <= fault_d;
            busy_q      <= (state_d == S_DISPENSE) || (state_d == S_CHANGE);
        end
    end

    assign bus.credit      = credit_q;
    assign bus.disp_req    = disp_req_q;
    assign bus.disp_item   = disp_item_q;
    assign bus.chg_pulse   = chg_q;
    assign bus.coin_reject = rej_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.disp_fault  = fault_q;
    assign bus.busy        = busy_q;

endmodule
